// File: rtl/host_output_schedule_pkg.sv
// Shared descriptor layout and scheduler state encodings for the host output scheduler.
// Descriptor = {inport[3:0], bufid[8:0]}; inport 4'hf marks a discard (free-only) descriptor.
package host_output_schedule_pkg;

  localparam int DESC_W     = 13;
  localparam int INPORT_MSB = 12;
  localparam int INPORT_LSB = 9;
  localparam int BUFID_MSB  = 8;
  localparam int BUFID_LSB  = 0;

  localparam logic [3:0] DISCARD_INPORT = 4'hf;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    WAIT_READ_S = 3'd2,
    WAIT_FREE_S = 3'd3,
    GUARD_S     = 3'd4
  } hos_state_e;

  function automatic logic is_discard(input logic [DESC_W-1:0] desc);
    return desc[INPORT_MSB:INPORT_LSB] == DISCARD_INPORT;
  endfunction

endpackage

// File: rtl/host_output_schedule_fifo.sv
// Show-ahead descriptor FIFO: head_o is valid whenever empty_o is low, no read latency.
// A push while full is accepted only if a pop happens in the same cycle; otherwise ignored.
module host_descriptor_fifo #(
  parameter int AW = 4,
  parameter int DW = 13
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   usedw_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign usedw_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/host_output_schedule.sv
// Host output scheduler: queues descriptors and issues one at a time, waiting for read/free completion.
// Issue 2 cycles after a push into an empty, idle scheduler; descriptors written while full (no pop) are dropped.
module host_output_schedule
  import host_output_schedule_pkg::*;
#(
  parameter int FIFO_AW        = 4,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DESC_W-1:0] iv_pkt_descriptor,
  input  logic              i_pkt_descriptor_wr,
  output logic [DESC_W-1:0] ov_pkt_descriptor,
  output logic              o_pkt_descriptor_wr,
  input  logic              i_pkt_descriptor_ready,
  input  logic              i_pkt_last_cycle_rx,
  output logic [FIFO_AW:0]  ov_fifo_usedw,
  output logic              o_fifo_full,
  output logic              o_overflow_pulse,
  output logic [15:0]       ov_overflow_cnt,
  output logic [15:0]       ov_timeout_cnt,
  output logic [2:0]        hos_state
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  hos_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DESC_W-1:0] desc_q, desc_d;
  logic              idle_q;
  logic              ovf_pulse_q;
  logic [15:0]       ovf_cnt_q, to_cnt_q;

  logic [DESC_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic              pop, timeout, drop;

  host_descriptor_fifo #(.AW(FIFO_AW), .DW(DESC_W)) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .push_i     (i_pkt_descriptor_wr),
    .push_dat_i (iv_pkt_descriptor),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usedw_o    (ov_fifo_usedw)
  );

  assign drop = i_pkt_descriptor_wr && fifo_full && !pop;

  // IDLE only pops once it has been idle for a full cycle, giving read control a settle cycle after completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    desc_d  = desc_q;
    pop     = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && idle_q) begin
          pop     = 1'b1;
          desc_d  = fifo_head;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = is_discard(desc_q) ? WAIT_FREE_S : WAIT_READ_S;
      end
      WAIT_READ_S: begin
        if (i_pkt_last_cycle_rx) begin
          cnt_d   = '0;
          state_d = GUARD_S;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_FREE_S: begin
        if (i_pkt_descriptor_ready) begin
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GUARD_S: begin
        if (cnt_q >= GUARD_LAST) state_d = IDLE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      desc_q      <= '0;
      idle_q      <= 1'b0;
      ovf_pulse_q <= 1'b0;
      ovf_cnt_q   <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      desc_q      <= desc_d;
      idle_q      <= (state_q == IDLE);
      ovf_pulse_q <= drop;
      if (drop && ovf_cnt_q != 16'hffff)   ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (timeout && to_cnt_q != 16'hffff) to_cnt_q  <= to_cnt_q + 16'd1;
    end
  end

  assign ov_pkt_descriptor   = desc_q;
  assign o_pkt_descriptor_wr = (state_q == ISSUE);
  assign o_fifo_full         = fifo_full;
  assign o_overflow_pulse    = ovf_pulse_q;
  assign ov_overflow_cnt     = ovf_cnt_q;
  assign ov_timeout_cnt      = to_cnt_q;
  assign hos_state           = state_q;

endmodule
